// File: rtl/input_port.sv
// input_port: synchronise, debounce and capture rising edges of board inputs as {pending, stable}.
// Optional macro INPUT_PORT_IRQ_EN adds a one-cycle irq pulse on each new event.
module input_port #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic             clk,
  input  logic             n_async_reset,
  input  logic [WIDTH-1:0] raw_i,
  input  logic             rd_strobe_i,
  output logic [15:0]      data_o,
  output logic             event_o,
  output logic             irq_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES-1);
  logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d, pending_q, pending_d, rise;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [15:0]      data_q, data_d;
  logic [7:0]       pend8, stab8;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      // a mismatch that has lasted the full window is accepted; any return to stable restarts
      cnt_d[i]    = (sync2_q[i] == stable_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == LAST) ? sync2_q[i] : stable_q[i];
    end
    rise      = stable_d & ~stable_q;
    pending_d = rise | (pending_q & ~{WIDTH{rd_strobe_i}});
    pend8     = '0;
    stab8     = '0;
    pend8[WIDTH-1:0] = pending_q;
    stab8[WIDTH-1:0] = stable_q;
    data_d    = {pend8, stab8};
  end
  always_ff @(posedge clk or negedge n_async_reset) begin
    if (!n_async_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      cnt_q     <= '{default: '0};
      data_q    <= '0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
    end
  end
  assign data_o  = data_q;
  assign event_o = |pending_q;
`ifdef INPUT_PORT_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge n_async_reset) begin
    if (!n_async_reset) irq_q <= 1'b0;
    else                irq_q <= |(rise & ~pending_q);
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif
endmodule
